boot_loader: RTL and testbench
==============================

# boot_loader

Serial program loader and bus switch placed between the `cpu` memory port and the board's byte-wide RAM. After reset it passes CPU bus cycles straight through to memory. On receiving a framed UART download, it holds the CPU in reset, takes over the bus, and writes the payload bytes into RAM. It then releases the CPU so execution starts from the freshly loaded image.

## Interface
- `CLK_DIV`, 217 — clocks per UART bit. 25 MHz / 115200 baud; must be ≥ 4.
- `SYNC`, 8'hA5 — frame start byte.

Ports:
- `clock` in 1 — single system clock.
- `reset_n` in 1 — asynchronous, active-low reset.
- `rx` in 1 — UART 8N1 serial input; idle high; asynchronous to `clock`.
- `cpu_address` in 20 — CPU byte address.
- `cpu_o_data` in 8 — CPU write data.
- `cpu_we` in 1 — CPU write strobe.
- `address` out 20 — RAM address.
- `o_data` out 8 — RAM write data.
- `we` out 1 — RAM write strobe; RAM writes on posedge `clock`.
- `cpu_reset_n` out 1 — active-low reset to the `cpu` block.
- `busy` out 1 — high while a frame is in progress.
- `ferr` out 1 — sticky UART framing error.

## Operation
- **RX front end**
  - `rx` passes through a 2-FF synchronizer; both FFs reset to 1.
  - Start is a synchronized falling edge seen while the receiver is idle.
  - At `CLK_DIV/2` clocks after the edge, the line is re-sampled. If it is high, the event is a glitch: return to idle, no byte.
  - Data bits are then sampled every `CLK_DIV` clocks, LSB first, 8 bits. The stop bit is sampled `CLK_DIV` clocks after bit 7.
  - Stop = 1: one-cycle `byte_valid` pulse with `byte`.
  - Stop = 0: byte discarded, `ferr` set, protocol FSM forced to IDLE.
- **Protocol FSM** states: IDLE, A0, A1, A2, L0, L1, DATA.
  - IDLE: a byte equal to `SYNC` → A0 and clears `ferr`. Any other byte is ignored.
  - A0/A1/A2: address bits [7:0], [15:8], [19:16]. In A2, byte bits [7:4] are ignored.
  - L0/L1: 16-bit count N, little-endian. In L1, N = 0 → IDLE; otherwise → DATA.
  - DATA: each byte issues one write at the pointer, then the pointer increments modulo 2^20 (FFFFF wraps to 00000) and N decrements. After the write that brings N to 0 → IDLE.
- **Bus switch**
  - FSM == IDLE: `address`/`o_data`/`we` = `cpu_address`/`cpu_o_data`/`cpu_we`, combinational pass-through.
  - Otherwise: the loader drives the pointer, the byte register, and its registered write strobe. `cpu_we` is ignored.
- **Status outputs**
  - `busy` = (FSM != IDLE).
  - `cpu_reset_n` is registered: it equals `!busy` delayed one clock, so it deasserts one cycle after `busy` rises and reasserts one cycle after the return to IDLE.
- **Reset**
  - Reset values: FSM IDLE, pointer 0, count 0, loader strobe 0, `busy` 0, `ferr` 0, `cpu_reset_n` 0.
  - `cpu_reset_n` rises on the first `clock` edge after `reset_n` deasserts.
  - `reset_n` low mid-frame aborts immediately; no partial-state carry-over.
- **Frame errors**
  - A framing error mid-frame aborts the frame and releases the CPU.
  - Bytes already written stay in RAM.

## Timing
- `byte_valid` asserts on the cycle after the stop-bit sample.
- The loader write strobe is high for exactly 1 cycle, on the cycle after the `byte_valid` that carries a DATA byte. `address`/`o_data` are stable in that cycle.
- Pointer and count update on the same edge that ends the write strobe.
- The final DATA write completes before `busy` falls. The FSM returns to IDLE on the edge ending the last strobe, and `cpu_reset_n` rises 1 cycle later.
- Byte spacing is set by the UART, with ≥ `CLK_DIV` cycles between writes. There is no backpressure; the RAM must accept a write every cycle.
- A new start bit may begin during the stop-bit cycle of the previous byte; back-to-back frames must be received without loss.

## Test plan
- **Pass-through:** after reset with no `rx` activity, drive `cpu_address`=12345, `cpu_o_data`=3C, `cpu_we`=1 → same values on `address`/`o_data`/`we` in the same cycle; `cpu_reset_n`=1 from the 1st clock after reset.
- **Basic load** (`CLK_DIV`=4): send A5 00 01 00 03 00 11 22 33.
  - Writes 11@00100, 22@00101, 33@00102, each with a 1-cycle `we`.
  - `cpu_reset_n` low from 1 cycle after A5 is accepted until 1 cycle after the last write; `cpu_we` pulses during the frame do not reach `we`.
- **Wrap and N=0:** send A5 FF FF FF 02 00 AA BB → AA@FFFFF, BB@00000. Then send A5 00 00 00 00 00 → no writes, `busy` drops after L1.
- **Framing error:** send A5 00 00 00 05 00 01 followed by a byte with stop=0.
  - 01 is written, `ferr`=1, FSM returns to IDLE, `cpu_reset_n` returns to 1.
  - `ferr` clears on the next A5.
- **Glitch and noise:** a 1-cycle low pulse on `rx` → no byte, no state change. Bytes 00 and 5A received in IDLE → ignored, `busy` stays 0.
- **Reset mid-frame:** assert `reset_n` low during DATA → all outputs at their reset values asynchronously. After release, a fresh frame loads correctly.

Source files
------------

// File: rtl/boot_loader.sv
// Serial program loader and RAM bus switch. Passes CPU bus cycles through to RAM while
// idle; on a framed UART download it holds the CPU in reset and writes the payload.
module boot_loader #(
   parameter int unsigned CLK_DIV = 217,
   parameter logic [7:0]  SYNC    = 8'hA5
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        rx,
   input  logic [19:0] cpu_address,
   input  logic [7:0]  cpu_o_data,
   input  logic        cpu_we,
   output logic [19:0] address,
   output logic [7:0]  o_data,
   output logic        we,
   output logic        cpu_reset_n,
   output logic        busy,
   output logic        ferr
);

   localparam int unsigned    CntW    = $clog2(CLK_DIV);
   localparam logic [CntW-1:0] CntFull = CntW'(CLK_DIV - 1);
   localparam logic [CntW-1:0] CntHalf = CntW'(CLK_DIV / 2 - 1);

   typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
   typedef enum logic [2:0] {StIdle, StA0, StA1, StA2, StL0, StL1, StData} state_e;

   // RX front end state
   logic            rx_s1_q, rx_s2_q, rx_prev_q;
   rx_state_e       rx_state_q, rx_state_d;
   logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]      rx_bit_q, rx_bit_d;
   logic [7:0]      rx_shift_q, rx_shift_d;
   logic            byte_valid_q, byte_valid_d;
   logic            frame_err_q, frame_err_d;

   // Protocol / loader state
   state_e      state_q, state_d;
   logic [19:0] ptr_q, ptr_d;
   logic [15:0] count_q, count_d;
   logic [7:0]  data_q, data_d;
   logic        ld_we_q, ld_we_d;
   logic        ferr_q, ferr_d;
   logic        cpu_rst_n_q, cpu_rst_n_d;

   // Two-stage synchronizer plus previous sample for falling-edge detection; idle high.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rx_s1_q   <= 1'b1;
         rx_s2_q   <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         rx_s1_q   <= rx;
         rx_s2_q   <= rx_s1_q;
         rx_prev_q <= rx_s2_q;
      end
   end

   // UART receiver registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rx_state_q   <= RxIdle;
         rx_cnt_q     <= '0;
         rx_bit_q     <= '0;
         rx_shift_q   <= '0;
         byte_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         rx_state_q   <= rx_state_d;
         rx_cnt_q     <= rx_cnt_d;
         rx_bit_q     <= rx_bit_d;
         rx_shift_q   <= rx_shift_d;
         byte_valid_q <= byte_valid_d;
         frame_err_q  <= frame_err_d;
      end
   end

   // UART receiver next state: mid-bit sampling, glitch rejection, stop-bit check.
   always_comb begin
      rx_state_d   = rx_state_q;
      rx_cnt_d     = rx_cnt_q;
      rx_bit_d     = rx_bit_q;
      rx_shift_d   = rx_shift_q;
      byte_valid_d = 1'b0;
      frame_err_d  = 1'b0;
      unique case (rx_state_q)
         RxIdle: begin
            if (rx_prev_q && !rx_s2_q) begin
               rx_state_d = RxStart;
               rx_cnt_d   = CntHalf;
            end
         end
         RxStart: begin
            if (rx_cnt_q == '0) begin
               if (rx_s2_q) begin
                  rx_state_d = RxIdle;
               end else begin
                  rx_state_d = RxData;
                  rx_cnt_d   = CntFull;
                  rx_bit_d   = 3'd0;
               end
            end else begin
               rx_cnt_d = rx_cnt_q - 1'b1;
            end
         end
         RxData: begin
            if (rx_cnt_q == '0) begin
               rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
               rx_cnt_d   = CntFull;
               if (rx_bit_q == 3'd7) begin
                  rx_state_d = RxStop;
               end else begin
                  rx_bit_d = rx_bit_q + 3'd1;
               end
            end else begin
               rx_cnt_d = rx_cnt_q - 1'b1;
            end
         end
         RxStop: begin
            // Returning to idle right after the mid-stop sample lets the next start edge in.
            if (rx_cnt_q == '0) begin
               rx_state_d   = RxIdle;
               byte_valid_d = rx_s2_q;
               frame_err_d  = !rx_s2_q;
            end else begin
               rx_cnt_d = rx_cnt_q - 1'b1;
            end
         end
         default: rx_state_d = RxIdle;
      endcase
   end

   // Protocol FSM and loader registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         ptr_q       <= '0;
         count_q     <= '0;
         data_q      <= '0;
         ld_we_q     <= 1'b0;
         ferr_q      <= 1'b0;
         cpu_rst_n_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         count_q     <= count_d;
         data_q      <= data_d;
         ld_we_q     <= ld_we_d;
         ferr_q      <= ferr_d;
         cpu_rst_n_q <= cpu_rst_n_d;
      end
   end

   // Protocol FSM next state: header parsing, payload writes, framing-error abort.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      count_d     = count_q;
      data_d      = data_q;
      ld_we_d     = 1'b0;
      ferr_d      = ferr_q;
      cpu_rst_n_d = !busy;
      if (frame_err_q) begin
         state_d = StIdle;
         ferr_d  = 1'b1;
      end else if (ld_we_q) begin
         // Pointer and count advance on the edge that ends the write strobe.
         ptr_d   = ptr_q + 20'd1;
         count_d = count_q - 16'd1;
         if (count_q == 16'd1) begin
            state_d = StIdle;
         end
      end else if (byte_valid_q) begin
         unique case (state_q)
            StIdle: begin
               if (rx_shift_q == SYNC) begin
                  state_d = StA0;
                  ferr_d  = 1'b0;
               end
            end
            StA0: begin
               ptr_d[7:0] = rx_shift_q;
               state_d    = StA1;
            end
            StA1: begin
               ptr_d[15:8] = rx_shift_q;
               state_d     = StA2;
            end
            StA2: begin
               ptr_d[19:16] = rx_shift_q[3:0];
               state_d      = StL0;
            end
            StL0: begin
               count_d[7:0] = rx_shift_q;
               state_d      = StL1;
            end
            StL1: begin
               count_d[15:8] = rx_shift_q;
               state_d       = ({rx_shift_q, count_q[7:0]} == 16'd0) ? StIdle : StData;
            end
            StData: begin
               data_d  = rx_shift_q;
               ld_we_d = 1'b1;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // Bus switch and status outputs.
   always_comb begin
      busy        = (state_q != StIdle);
      address     = busy ? ptr_q : cpu_address;
      o_data      = busy ? data_q : cpu_o_data;
      we          = busy ? ld_we_q : cpu_we;
      cpu_reset_n = cpu_rst_n_q;
      ferr        = ferr_q;
   end

endmodule

// File: tb/tb_boot_loader.sv
// Directed self-checking bench for boot_loader with a short UART bit period.
module tb_boot_loader;

   localparam int unsigned Div = 4;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        rx = 1'b1;
   logic [19:0] cpu_address = '0;
   logic [7:0]  cpu_o_data = '0;
   logic        cpu_we = 1'b0;
   logic [19:0] address;
   logic [7:0]  o_data;
   logic        we;
   logic        cpu_reset_n;
   logic        busy;
   logic        ferr;

   int checks = 0;
   int errors = 0;

   boot_loader #(.CLK_DIV(Div), .SYNC(8'hA5)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .rx          (rx),
      .cpu_address (cpu_address),
      .cpu_o_data  (cpu_o_data),
      .cpu_we      (cpu_we),
      .address     (address),
      .o_data      (o_data),
      .we          (we),
      .cpu_reset_n (cpu_reset_n),
      .busy        (busy),
      .ferr        (ferr)
   );

   always #5 clock = ~clock;

   // Cycle counter and bus/status monitor, sampled on the falling edge.
   int          cyc = 0;
   logic [19:0] wr_addr [64];
   logic [7:0]  wr_data [64];
   int          wr_cyc [64];
   int          wr_n = 0;
   logic        busy_prev = 1'b0;
   logic        rst_prev = 1'b0;
   int          t_busy_rise = 0, t_busy_fall = 0, t_rst_fall = 0, t_rst_rise = 0;
   int          busy_rises = 0;

   always @(posedge clock) cyc <= cyc + 1;

   always @(negedge clock) begin
      if (busy && we && wr_n < 64) begin
         wr_addr[wr_n] <= address;
         wr_data[wr_n] <= o_data;
         wr_cyc[wr_n]  <= cyc;
         wr_n          <= wr_n + 1;
      end
      busy_prev <= busy;
      rst_prev  <= cpu_reset_n;
      if (busy && !busy_prev) begin
         t_busy_rise <= cyc;
         busy_rises  <= busy_rises + 1;
      end
      if (!busy && busy_prev) t_busy_fall <= cyc;
      if (!cpu_reset_n && rst_prev) t_rst_fall <= cyc;
      if (cpu_reset_n && !rst_prev) t_rst_rise <= cyc;
   end

   logic [7:0] tx_q [$];

   // One 8N1 character, starting and ending on a falling clock edge.
   task automatic send_byte(input logic [7:0] b, input logic stop);
      rx = 1'b0;
      repeat (Div) @(negedge clock);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (Div) @(negedge clock);
      end
      rx = stop;
      repeat (Div) @(negedge clock);
      rx = 1'b1;
   endtask

   task automatic send_q();
      foreach (tx_q[i]) send_byte(tx_q[i], 1'b1);
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      @(negedge clock);
      while ((busy || !cpu_reset_n) && n < 400) begin
         @(negedge clock);
         n++;
      end
      checks++;
      if (n >= 400) begin
         errors++;
         $display("FAIL %s_idle_timeout busy=%b cpu_reset_n=%b want idle", name, busy, cpu_reset_n);
      end
      repeat (2) @(negedge clock);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clock);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++;
      if (ferr !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b want 0", ferr); end
      checks++;
      if (cpu_reset_n !== 1'b0) begin
         errors++; $display("FAIL reset_cpu_reset_n got %b want 0", cpu_reset_n);
      end
      checks++;
      if (we !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", we); end
      reset_n = 1'b1;
      #1;
      checks++;
      if (cpu_reset_n !== 1'b0) begin
         errors++; $display("FAIL release_before_edge got %b want 0", cpu_reset_n);
      end
      @(posedge clock);
      #1;
      checks++;
      if (cpu_reset_n !== 1'b1) begin
         errors++; $display("FAIL release_first_edge got %b want 1", cpu_reset_n);
      end
   endtask

   task automatic test_pass_through();
      @(negedge clock);
      cpu_address = 20'h12345;
      cpu_o_data  = 8'h3C;
      cpu_we      = 1'b1;
      #1;
      checks++;
      if (address !== 20'h12345) begin
         errors++; $display("FAIL pt_address got %h want 12345", address);
      end
      checks++;
      if (o_data !== 8'h3C) begin errors++; $display("FAIL pt_data got %h want 3c", o_data); end
      checks++;
      if (we !== 1'b1) begin errors++; $display("FAIL pt_we got %b want 1", we); end
      cpu_we = 1'b0;
      #1;
      checks++;
      if (we !== 1'b0) begin errors++; $display("FAIL pt_we_low got %b want 0", we); end
   endtask

   task automatic test_basic_load();
      logic [19:0] ea [3] = '{20'h00100, 20'h00101, 20'h00102};
      logic [7:0]  ed [3] = '{8'h11, 8'h22, 8'h33};
      int base = wr_n;
      @(negedge clock);
      cpu_address = 20'hABCDE;
      cpu_o_data  = 8'hEE;
      cpu_we      = 1'b1;  // held high: must never reach the RAM during the frame
      tx_q = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33};
      send_q();
      wait_idle("basic");
      checks++;
      if (wr_n - base !== 3) begin
         errors++; $display("FAIL basic_write_count got %0d want 3", wr_n - base);
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (wr_addr[base+i] !== ea[i] || wr_data[base+i] !== ed[i]) begin
            errors++;
            $display("FAIL basic_write%0d got %h@%h want %h@%h", i, wr_data[base+i],
                     wr_addr[base+i], ed[i], ea[i]);
         end
      end
      checks++;
      if (t_rst_fall !== t_busy_rise + 1) begin
         errors++; $display("FAIL basic_rst_fall got %0d want %0d", t_rst_fall, t_busy_rise + 1);
      end
      checks++;
      if (t_busy_fall !== wr_cyc[base+2] + 1) begin
         errors++;
         $display("FAIL basic_busy_fall got %0d want %0d", t_busy_fall, wr_cyc[base+2] + 1);
      end
      checks++;
      if (t_rst_rise !== t_busy_fall + 1) begin
         errors++; $display("FAIL basic_rst_rise got %0d want %0d", t_rst_rise, t_busy_fall + 1);
      end
      checks++;
      if (we !== 1'b1 || address !== 20'hABCDE) begin
         errors++; $display("FAIL basic_pt_restored got we=%b addr=%h want 1 abcde", we, address);
      end
      cpu_we = 1'b0;
   endtask

   task automatic test_wrap_zero();
      int base = wr_n;
      int rises;
      tx_q = '{8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'hAA, 8'hBB};
      send_q();
      wait_idle("wrap");
      checks++;
      if (wr_n - base !== 2) begin
         errors++; $display("FAIL wrap_write_count got %0d want 2", wr_n - base);
      end
      checks++;
      if (wr_addr[base] !== 20'hFFFFF || wr_data[base] !== 8'hAA) begin
         errors++;
         $display("FAIL wrap_write0 got %h@%h want aa@fffff", wr_data[base], wr_addr[base]);
      end
      checks++;
      if (wr_addr[base+1] !== 20'h00000 || wr_data[base+1] !== 8'hBB) begin
         errors++;
         $display("FAIL wrap_write1 got %h@%h want bb@00000", wr_data[base+1], wr_addr[base+1]);
      end
      base  = wr_n;
      rises = busy_rises;
      tx_q = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      send_q();
      wait_idle("nzero");
      checks++;
      if (wr_n !== base) begin
         errors++; $display("FAIL nzero_writes got %0d want 0", wr_n - base);
      end
      checks++;
      if (busy_rises !== rises + 1) begin
         errors++; $display("FAIL nzero_frame_seen got %0d want %0d", busy_rises, rises + 1);
      end
   endtask

   task automatic test_frame_err();
      int base = wr_n;
      tx_q = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h01};
      send_q();
      send_byte(8'hC3, 1'b0);
      wait_idle("ferr");
      checks++;
      if (wr_n - base !== 1 || wr_addr[base] !== 20'h0 || wr_data[base] !== 8'h01) begin
         errors++;
         $display("FAIL ferr_write got n=%0d %h@%h want 1 01@00000", wr_n - base,
                  wr_data[base], wr_addr[base]);
      end
      checks++;
      if (ferr !== 1'b1) begin errors++; $display("FAIL ferr_set got %b want 1", ferr); end
      checks++;
      if (busy !== 1'b0 || cpu_reset_n !== 1'b1) begin
         errors++;
         $display("FAIL ferr_release got busy=%b cpu_reset_n=%b want 0 1", busy, cpu_reset_n);
      end
      send_byte(8'hA5, 1'b1);
      repeat (4) @(negedge clock);
      checks++;
      if (ferr !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("FAIL ferr_clear got ferr=%b busy=%b want 0 1", ferr, busy);
      end
      tx_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      send_q();
      wait_idle("ferr_close");
   endtask

   task automatic test_glitch_noise();
      int base = wr_n;
      int rises = busy_rises;
      @(negedge clock);
      rx = 1'b0;
      @(negedge clock);
      rx = 1'b1;
      repeat (20) @(negedge clock);
      checks++;
      if (busy !== 1'b0 || ferr !== 1'b0) begin
         errors++; $display("FAIL glitch_state got busy=%b ferr=%b want 0 0", busy, ferr);
      end
      @(negedge clock);
      rx = 1'b0;
      @(negedge clock);
      rx = 1'b1;
      repeat (3) @(negedge clock);
      // A real frame right after a glitch must still be received.
      tx_q = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      send_q();
      wait_idle("glitch");
      checks++;
      if (busy_rises !== rises + 1) begin
         errors++; $display("FAIL glitch_then_frame got %0d want %0d", busy_rises, rises + 1);
      end
      tx_q = '{8'h00, 8'h5A};
      send_q();
      repeat (10) @(negedge clock);
      checks++;
      if (busy_rises !== rises + 1 || busy !== 1'b0) begin
         errors++; $display("FAIL noise_ignored got rises=%0d busy=%b want %0d 0", busy_rises,
                            busy, rises + 1);
      end
      checks++;
      if (wr_n !== base) begin
         errors++; $display("FAIL noise_writes got %0d want 0", wr_n - base);
      end
   endtask

   task automatic test_reset_mid();
      int base = wr_n;
      int n = 0;
      tx_q = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h04, 8'h00, 8'h11};
      send_q();
      while (wr_n == base && n < 50) begin
         @(negedge clock);
         n++;
      end
      @(negedge clock);
      checks++;
      if (wr_n - base !== 1 || wr_addr[base] !== 20'h00200 || wr_data[base] !== 8'h11) begin
         errors++;
         $display("FAIL mid_first_write got n=%0d %h@%h want 1 11@00200", wr_n - base,
                  wr_data[base], wr_addr[base]);
      end
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL mid_in_data got busy=%b want 1", busy); end
      cpu_address = 20'h55555;
      cpu_we      = 1'b1;
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || cpu_reset_n !== 1'b0 || ferr !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_status got busy=%b cpu_reset_n=%b ferr=%b want 0 0 0", busy,
                  cpu_reset_n, ferr);
      end
      checks++;
      if (we !== 1'b1 || address !== 20'h55555) begin
         errors++; $display("FAIL mid_reset_bus got we=%b addr=%h want 1 55555", we, address);
      end
      repeat (2) @(negedge clock);
      cpu_we  = 1'b0;
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      checks++;
      if (cpu_reset_n !== 1'b1) begin
         errors++; $display("FAIL mid_release got %b want 1", cpu_reset_n);
      end
      @(negedge clock);
      base = wr_n;
      tx_q = '{8'hA5, 8'h10, 8'h00, 8'h00, 8'h01, 8'h00, 8'h77};
      send_q();
      wait_idle("fresh");
      checks++;
      if (wr_n - base !== 1 || wr_addr[base] !== 20'h00010 || wr_data[base] !== 8'h77) begin
         errors++;
         $display("FAIL fresh_write got n=%0d %h@%h want 1 77@00010", wr_n - base,
                  wr_data[base], wr_addr[base]);
      end
   endtask

   initial begin
      test_reset();
      test_pass_through();
      test_basic_load();
      test_wrap_zero();
      test_frame_err();
      test_glitch_noise();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
